bidir_shift_reg: RTL and testbench
==================================

BIDIR_SHIFT_REG -- requirements
Module: bidir_shift_reg

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock port is clk and the reset port is rst.
REQ-002 The block SHALL expose parameter D_SIZE, default 4, as the register width in bits (legal values >= 2).
REQ-003 Port clk, input, 1 bit, SHALL be the sole clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-005 Port in, input, 1 bit, SHALL be the serial data bit shifted into the register.
REQ-006 Port en, input, 1 bit, SHALL be the shift enable, active-high.
REQ-007 Port dir, input, 1 bit, SHALL select direction: 0 = shift left (toward MSB), 1 = shift right (toward LSB).
REQ-008 Port out, output, D_SIZE bits, SHALL be the registered parallel contents of the shift register.

Function
REQ-009 The register SHALL be a single D_SIZE-bit state vector driven directly onto out, with no combinational path from any input to out.
REQ-010 On a rising clk edge with rst=0, en=1, dir=0, the register SHALL load {out[D_SIZE-2:0], in}: bits move up one position, in enters bit 0, and the old MSB is discarded.
REQ-011 On a rising clk edge with rst=0, en=1, dir=1, the register SHALL load {in, out[D_SIZE-1:1]}: bits move down one position, in enters bit D_SIZE-1, and the old LSB is discarded.
REQ-012 On a rising clk edge with rst=0, en=0, the register SHALL hold its value regardless of in and dir.
REQ-013 Latency SHALL be one clock: a value of in sampled at edge N appears in out immediately after edge N.
REQ-014 in, en and dir SHALL be sampled only at the rising clk edge; changes between edges SHALL have no effect.
REQ-015 A dir change SHALL take effect on the next enabled edge, with no pipeline flush, no lost bit and no extra cycle.
REQ-016 There SHALL be no saturation or wrap: bits shifted out are lost, and after D_SIZE consecutive enabled shifts in one direction, out consists entirely of the last D_SIZE in values.
REQ-017 The block SHALL have no other state, flags or outputs.

Reset
REQ-018 When rst=1 at a rising clk edge, out SHALL become all zeros, regardless of en, dir and in.
REQ-019 rst SHALL have priority over en; a reset asserted mid-sequence SHALL discard all shifted data.
REQ-020 out SHALL be undefined from power-up until the first clk edge with rst=1; no asynchronous clear SHALL exist.
REQ-021 On the first edge after rst deasserts, normal operation per REQ-010 to REQ-012 SHALL apply.

Verification
REQ-022 Reset: rst=1 for one edge with any in, en or dir -> out=0000 (D_SIZE=4).
REQ-023 Shift left: from 0000 with en=1, dir=0, apply in=1,0,1,1 on four edges -> out=0001, 0010, 0101, 1011.
REQ-024 Shift right: from 1011 with en=1, dir=1, apply in=1, then 0, then 0 -> out=1101, 0110, 0011.
REQ-025 Hold: from 0110 with en=0, toggle in and dir for 3 edges -> out stays 0110.
REQ-026 Fill and flush: with en=1, dir=0, apply in=1 for 5 edges -> 1111 stays 1111 on the 5th edge; then in=0 for 4 edges -> 0000.
REQ-027 Mid-operation reset: from 1011 with en=1, assert rst=1 for one edge -> 0000; next edge with rst=0, in=1, dir=0 -> 0001.

Source files
------------

// File: rtl/bidir_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : bidir_shift_reg
// Brief    : D_SIZE-bit serial-in / parallel-out shift register, left or right
// Revision : 1.0 - initial release
// ============================================================================
module bidir_shift_reg #(
    parameter int D_SIZE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    input  logic              en,
    input  logic              dir,
    output logic [D_SIZE-1:0] out
);

    logic [D_SIZE-1:0] shift_q;
    logic [D_SIZE-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (en) begin
            if (dir) begin
                shift_d = {in, shift_q[D_SIZE-1:1]};
            end else begin
                shift_d = {shift_q[D_SIZE-2:0], in};
            end
        end
    end

    // Reset wins over enable; no asynchronous clear by design.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign out = shift_q;

endmodule
`default_nettype wire

// File: tb/tb_bidir_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_bidir_shift_reg
// Brief    : Self-checking bench: directed vectors plus random traffic vs model
// Revision : 1.0 - initial release
// ============================================================================
module tb_bidir_shift_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in  = 1'b0;
    logic       en  = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] out4;
    logic [6:0] out7;

    int total = 0;
    int bad   = 0;

    logic [63:0] m4 = '0;
    logic [63:0] m7 = '0;
    logic        valid = 1'b0;

    always #5 clk = ~clk;

    bidir_shift_reg #(.D_SIZE(4)) u_dut4 (
        .clk (clk), .rst (rst), .in (in), .en (en), .dir (dir), .out (out4)
    );

    bidir_shift_reg #(.D_SIZE(7)) u_dut7 (
        .clk (clk), .rst (rst), .in (in), .en (en), .dir (dir), .out (out7)
    );

    // Register viewed as an unsigned number: left shift is *2 + in modulo 2^w,
    // right shift is /2 with in weighted 2^(w-1).
    function automatic logic [63:0] nxt(input logic [63:0] cur, input int w,
                                        input logic r, input logic e,
                                        input logic d, input logic i);
        logic [63:0] p;
        p = 64'd1 << w;
        if (r)       return 64'd0;
        else if (!e) return cur;
        else if (!d) return (cur * 2 + 64'(i)) % p;
        else         return cur / 2 + 64'(i) * (p / 2);
    endfunction

    always @(posedge clk) begin
        m4 <= nxt(m4, 4, rst, en, dir, in);
        m7 <= nxt(m7, 7, rst, en, dir, in);
        if (rst) valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (valid) begin
            total++;
            if (out4 !== m4[3:0]) begin
                bad++;
                $display("FAIL model4 t=%0t out=%b expected=%b", $time, out4, m4[3:0]);
            end
            total++;
            if (out7 !== m7[6:0]) begin
                bad++;
                $display("FAIL model7 t=%0t out=%b expected=%b", $time, out7, m7[6:0]);
            end
        end
    end

    // Inputs change just after the falling edge, with junk in between so that
    // only the value present at the rising edge should matter.
    task automatic step(input logic r, input logic e, input logic d, input logic i,
                        input bit glitch);
        @(negedge clk);
        #1;
        if (glitch) begin
            rst = ~r; en = ~e; dir = ~d; in = ~i;
            #2;
        end
        rst = r; en = e; dir = d; in = i;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [3:0] exp);
        total++;
        if (out4 !== exp) begin
            bad++;
            $display("FAIL %s dut out=%b expected=%b", name, out4, exp);
        end
        total++;
        if (m4[3:0] !== exp) begin
            bad++;
            $display("FAIL %s_model model=%b expected=%b", name, m4[3:0], exp);
        end
    endtask

    initial begin
        logic [3:0] seq [4];
        seq = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};

        step(1, 1, 1, 1, 0); lit("reset", 4'b0000);

        step(0, 1, 0, 1, 0); lit("left0", seq[0]);
        step(0, 1, 0, 0, 1); lit("left1", seq[1]);
        step(0, 1, 0, 1, 0); lit("left2", seq[2]);
        step(0, 1, 0, 1, 1); lit("left3", seq[3]);

        step(0, 1, 1, 1, 0); lit("right0", 4'b1101);
        step(0, 1, 1, 0, 0); lit("right1", 4'b0110);

        for (int k = 0; k < 3; k++) begin
            step(0, 0, k[0], ~k[0], 1); lit("hold", 4'b0110);
        end
        step(0, 1, 1, 0, 0); lit("right2", 4'b0011);

        step(0, 1, 0, 1, 0); lit("fill1", 4'b0111);
        step(0, 1, 0, 1, 0); lit("fill2", 4'b1111);
        step(0, 1, 0, 1, 0); lit("fill3", 4'b1111);
        step(0, 1, 0, 1, 0); lit("fill4", 4'b1111);
        step(0, 1, 0, 1, 0); lit("fill5", 4'b1111);
        step(0, 1, 0, 0, 0); lit("flush1", 4'b1110);
        step(0, 1, 0, 0, 0); lit("flush2", 4'b1100);
        step(0, 1, 0, 0, 0); lit("flush3", 4'b1000);
        step(0, 1, 0, 0, 0); lit("flush4", 4'b0000);

        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0, (k != 1), 0);
        end
        lit("pre_rst", 4'b1011);
        step(1, 1, 0, 1, 1); lit("mid_rst", 4'b0000);
        step(0, 1, 0, 1, 0); lit("post_rst", 4'b0001);

        for (int k = 0; k < 2000; k++) begin
            step(($urandom_range(31) == 0), ($urandom_range(3) != 0),
                 1'($urandom), 1'($urandom), 1'($urandom));
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
